// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive path: default widths, stage-2 state
// encoding and a reference Gray-to-binary helper.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH = 4;
    localparam int unsigned GRAY_CNT_W = 8;

    typedef enum logic {
        StUnprimed = 1'b0,
        StTrack    = 1'b1
    } state_e;

    // Prefix XOR from the MSB down; correct for any width up to 32 with zero upper bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, the inverse of the lab's binary-to-Gray encoder.
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_decoder.sv
// Two-stage Gray-to-binary receiver that classifies each sample against the previous one
// as hold, single step (with direction) or illegal jump, and keeps net/error counters.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH,
    parameter int unsigned CNT_W = GRAY_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] net_count,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] g1;
    logic             v1;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prev_inc;
    logic             is_step;
    logic             is_err;
    logic             is_up;
    state_e           state;

    gray_to_bin #(
        .WIDTH(WIDTH)
    ) u_gray_to_bin (
        .gray(g1),
        .bin (bin_cur)
    );

    // Clearing the lowest set bit leaves something only if two or more bits differ.
    assign diff     = g1 ^ prev_gray;
    assign is_err   = (diff & (diff - 1'b1)) != '0;
    assign is_step  = (diff != '0) && !is_err;
    assign prev_inc = prev_bin + 1'b1;
    assign is_up    = bin_cur == prev_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g1 <= '0;
            v1 <= 1'b0;
        end else begin
            g1 <= gray_in;
            v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StUnprimed;
            prev_gray <= '0;
            prev_bin  <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
            net_count <= '0;
            err_count <= '0;
        end else begin
            out_valid <= v1;
            step      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
            if (v1) begin
                bin_out   <= bin_cur;
                prev_gray <= g1;
                prev_bin  <= bin_cur;
                unique case (state)
                    StUnprimed: state <= StTrack;
                    StTrack: begin
                        if (is_step) begin
                            step      <= 1'b1;
                            dir       <= is_up;
                            net_count <= is_up ? net_count + 1'b1 : net_count - 1'b1;
                        end else if (is_err) begin
                            err <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: directed scenarios plus randomized walks, checked
// against an arithmetic model of sample-to-sample motion.
module tb_gray_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic       out_valid;
    logic [3:0] bin_out;
    logic       step;
    logic       dir;
    logic       err;
    logic [7:0] net_count;
    logic [7:0] err_count;

    gray_decoder #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .gray_in  (gray_in),
        .out_valid(out_valid),
        .bin_out  (bin_out),
        .step     (step),
        .dir      (dir),
        .err      (err),
        .net_count(net_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int step;
        int dir;
        int err;
        int net;
        int errc;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rst_edge = 1'b0;

    bit m_primed = 1'b0;
    int m_prev_g = 0;
    int m_prev_b = 0;
    int m_net = 0;
    int m_errc = 0;

    int hold_bin = 0;
    int hold_net = 0;
    int hold_errc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_edge = !rst_n;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int g2b(input int g);
        for (int v = 0; v < 16; v++) begin
            if ((v ^ (v >> 1)) == g) return v;
        end
        return -1;
    endfunction

    function automatic int b2g(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    task automatic model_push(input int g);
        exp_t e;
        int   b;
        int   d;
        b = g2b(g);
        e.bin = b;
        e.step = 0;
        e.dir = 0;
        e.err = 0;
        if (m_primed) begin
            d = $countones(4'(g ^ m_prev_g));
            if (d == 1) begin
                e.step = 1;
                e.dir = (((b - m_prev_b + 16) % 16) == 1) ? 1 : 0;
                m_net = (m_net + (e.dir == 1 ? 1 : 255)) % 256;
            end else if (d >= 2) begin
                e.err = 1;
                if (m_errc < 255) m_errc++;
            end
        end
        m_primed = 1'b1;
        m_prev_g = g;
        m_prev_b = b;
        e.net = m_net;
        e.errc = m_errc;
        e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    task automatic send(input logic [3:0] g);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        gray_in = g;
        model_push(int'(g));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            gray_in = 4'($urandom);
        end
    endtask

    // Samples whose output edge falls after the reset edge never appear.
    task automatic do_reset(input int n);
        exp_t keep[$];
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'($urandom);
        gray_in = 4'($urandom);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc <= cyc) keep.push_back(q[i]);
        end
        q = keep;
        m_primed = 1'b0;
        m_prev_g = 0;
        m_prev_b = 0;
        m_net = 0;
        m_errc = 0;
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            if (rst_edge) begin
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_bin", int'(bin_out), 0);
                chk("rst_flags", int'({step, dir, err}), 0);
                chk("rst_net", int'(net_count), 0);
                chk("rst_errc", int'(err_count), 0);
                hold_bin = 0;
                hold_net = 0;
                hold_errc = 0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", int'(out_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("bin", int'(bin_out), e.bin);
                    chk("step", int'(step), e.step);
                    chk("err", int'(err), e.err);
                    if (e.step == 1 || e.err == 1) chk("dir", int'(dir), e.dir);
                    chk("net_count", int'(net_count), e.net);
                    chk("err_count", int'(err_count), e.errc);
                    hold_bin = e.bin;
                    hold_net = e.net;
                    hold_errc = e.errc;
                end
            end else begin
                chk("idle_flags", int'({step, dir, err}), 0);
                chk("hold_bin", int'(bin_out), hold_bin);
                chk("hold_net", int'(net_count), hold_net);
                chk("hold_errc", int'(err_count), hold_errc);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    chk("missing_output", int'(out_valid), 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        int v;

        do_reset(2);
        send(4'b0000);
        send(4'b0001);
        send(4'b0011);
        send(4'b0010);
        idle(3);

        do_reset(2);
        send(4'b1000);
        send(4'b0000);
        send(4'b1000);
        idle(3);

        do_reset(2);
        send(4'b0000);
        send(4'b0011);
        send(4'b0010);
        idle(3);

        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 1) ? 4'b0011 : 4'b0000);
        end
        idle(3);

        send(4'b0001);
        do_reset(1);
        idle(2);
        send(4'b0110);
        send(4'b0111);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset($urandom_range(1, 3));
            end else if (r < 20) begin
                idle($urandom_range(1, 3));
            end else begin
                r = $urandom_range(0, 9);
                if (!m_primed || r >= 8) v = $urandom_range(0, 15);
                else if (r < 4) v = (m_prev_b + 1) % 16;
                else if (r < 7) v = (m_prev_b + 15) % 16;
                else v = m_prev_b;
                send(4'(b2g(v)));
            end
        end
        idle(5);

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
